// File: rtl/layer9_train_sequencer_if.sv
// Sample/result handshake bundle for layer9_train_sequencer, plus the shared
// element type used for layer inputs and outputs.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both 1. A valid source holds its payload
// stable until that edge; ready never depends combinationally on valid.

package layer9_train_sequencer_pkg;
    // One layer activation / target value, unsigned fixed point 0..1.
    typedef logic [7:0] zero2one_t;
    // Sum of nine |target - out| terms fits in 4 extra bits.
    localparam int unsigned ERR_W = $bits(zero2one_t) + 4;
endpackage

interface layer9_train_sequencer_if #(parameter int N = 16);
    import layer9_train_sequencer_pkg::*;

    // Sample channel: feeder -> sequencer
    logic                    s_valid;
    logic                    s_ready;
    logic                    s_train;
    zero2one_t [N-1:0]       s_in;
    zero2one_t [8:0]         s_target;

    // Result channel: sequencer -> consumer
    logic                    r_valid;
    logic                    r_ready;
    zero2one_t [8:0]         r_out;
    logic [ERR_W-1:0]        r_err;

    modport master (
        output s_valid, s_train, s_in, s_target, r_ready,
        input  s_ready, r_valid, r_out, r_err
    );

    modport slave (
        input  s_valid, s_train, s_in, s_target, r_ready,
        output s_ready, r_valid, r_out, r_err
    );
endinterface

// File: rtl/layer9_train_sequencer.sv
// layer9_train_sequencer: drives one 9-output learning layer through
// accept -> forward settle -> capture -> optional learn -> respond.
// Optional feature: define LAYER9_SEQ_ERRACC_EN to add a saturating 32-bit
// accumulator of r_err over completed results (port err_acc).

module layer9_train_sequencer
    import layer9_train_sequencer_pkg::*;
#(
    parameter int N       = 16,
    parameter int FWD_LAT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    layer9_train_sequencer_if.slave sif,
    input  logic                  flush,
    output logic                  layer_valid,
    output logic                  layer_learn,
    output zero2one_t [N-1:0]     layer_in,
    output zero2one_t [8:0]       layer_expected_out,
    input  zero2one_t [8:0]       layer_out,
    output logic [15:0]           sample_cnt,
    output logic [15:0]           learn_cnt,
    output logic [2:0]            dbg_state
`ifdef LAYER9_SEQ_ERRACC_EN
    ,
    output logic [31:0]           err_acc
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_CAPT  = 3'd2,
        ST_LEARN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        fwd_cnt;
    logic              train_q;
    zero2one_t [N-1:0] in_q;
    zero2one_t [8:0]   tgt_q;
    zero2one_t [8:0]   r_out_q;
    logic [ERR_W-1:0]  r_err_q;
    logic [ERR_W-1:0]  err_sum;
    logic [15:0]       sample_cnt_q;
    logic [15:0]       learn_cnt_q;

    // flush suppresses every side effect of the current cycle.
    logic accept, handshake, fwd_last;
    assign accept    = (state_q == ST_IDLE) && sif.s_valid && !flush;
    assign handshake = (state_q == ST_RESP) && sif.r_ready && !flush;
    assign fwd_last  = (fwd_cnt == 4'(FWD_LAT - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sif.s_valid) state_d = ST_FWD;
            ST_FWD:   if (fwd_last) state_d = ST_CAPT;
            ST_CAPT:  state_d = train_q ? ST_LEARN : ST_RESP;
            ST_LEARN: state_d = ST_RESP;
            ST_RESP:  if (sif.r_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        sif.s_ready = (state_q == ST_IDLE);
        sif.r_valid = (state_q == ST_RESP);
        layer_valid = (state_q == ST_FWD) || (state_q == ST_CAPT) || (state_q == ST_LEARN);
        layer_learn = (state_q == ST_LEARN);
    end

    // Error of the current layer output against the held target.
    always_comb begin
        err_sum = '0;
        for (int k = 0; k < 9; k++) begin
            if (tgt_q[k] >= layer_out[k]) err_sum = err_sum + ERR_W'(tgt_q[k] - layer_out[k]);
            else                          err_sum = err_sum + ERR_W'(layer_out[k] - tgt_q[k]);
        end
    end

    // Sample registers, forward counter, result capture and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q         <= '0;
            tgt_q        <= '0;
            train_q      <= 1'b0;
            fwd_cnt      <= '0;
            r_out_q      <= '0;
            r_err_q      <= '0;
            sample_cnt_q <= '0;
            learn_cnt_q  <= '0;
        end else begin
            if (accept) begin
                in_q    <= sif.s_in;
                tgt_q   <= sif.s_target;
                train_q <= sif.s_train;
                fwd_cnt <= '0;
            end else if (state_q == ST_FWD && !flush) begin
                fwd_cnt <= fwd_cnt + 4'd1;
            end
            if (state_q == ST_CAPT && !flush) begin
                r_out_q <= layer_out;
                r_err_q <= err_sum;
            end
            if (state_q == ST_LEARN && !flush) learn_cnt_q <= learn_cnt_q + 16'd1;
            if (handshake) sample_cnt_q <= sample_cnt_q + 16'd1;
        end
    end

    assign layer_in           = in_q;
    assign layer_expected_out = tgt_q;
    assign sif.r_out          = r_out_q;
    assign sif.r_err          = r_err_q;
    assign sample_cnt         = sample_cnt_q;
    assign learn_cnt          = learn_cnt_q;
    assign dbg_state          = state_q;

`ifdef LAYER9_SEQ_ERRACC_EN
    logic [31:0] acc_q;
    logic [32:0] acc_sum;
    assign acc_sum = {1'b0, acc_q} + 33'(r_err_q);

    // Saturating running error total; cleared by flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       acc_q <= '0;
        else if (flush)     acc_q <= '0;
        else if (handshake) acc_q <= acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    end

    assign err_acc = acc_q;
`endif

endmodule
